// File: rtl/fsm_dut_host_if.sv
// Job/result handshake bundle between a job source (master) and fsm_dut_host (slave).
`timescale 1ns/1ps
interface fsm_dut_host_if #(
  parameter int DATA_WIDTH = 8
) ();
  logic                  job_valid;
  logic                  job_ready;
  logic [DATA_WIDTH-1:0] job_data;
  logic                  job_abort;
  logic                  res_valid;
  logic                  res_ready;
  logic [DATA_WIDTH-1:0] res_data;
  logic [1:0]            res_status;

  modport master (
    output job_valid, job_data, job_abort, res_ready,
    input  job_ready, res_valid, res_data, res_status
  );

  modport slave (
    input  job_valid, job_data, job_abort, res_ready,
    output job_ready, res_valid, res_data, res_status
  );
endinterface

// File: rtl/fsm_dut_host.sv
// fsm_dut_host: initiator-side driver for a 4-state processing engine.
// Accepts one job at a time, issues start then commit/abort to the engine,
// and returns the engine result with a status code.
// Optional build macro FSM_DUT_HOST_CHECK_EN: compares the engine result with
// a locally computed expected value and reports status 11 on a difference.
`timescale 1ns/1ps
module fsm_dut_host #(
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  fsm_dut_host_if.slave         job_bus,
  output logic                  peer_enable,
  output logic [1:0]            peer_cmd,
  output logic [DATA_WIDTH-1:0] peer_data_in,
  input  logic [1:0]            peer_state,
  input  logic                  peer_busy,
  input  logic                  peer_done,
  input  logic                  peer_valid,
  input  logic [DATA_WIDTH-1:0] peer_data_out,
  output logic                  host_busy
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

  localparam logic [1:0] CMD_NOP    = 2'b00;
  localparam logic [1:0] CMD_START  = 2'b01;
  localparam logic [1:0] CMD_COMMIT = 2'b10;
  localparam logic [1:0] CMD_ABORT  = 2'b11;

  localparam logic [1:0] PEER_IDLE  = 2'b00;
  localparam logic [1:0] PEER_WAIT  = 2'b10;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_ABORTED = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;

  typedef enum logic [2:0] {
    H_IDLE, H_ISSUE, H_WAIT_PEER, H_DECIDE,
    H_WAIT_DONE, H_WAIT_IDLE, H_KILL, H_REPORT
  } state_t;

  state_t                state, state_nx;
  logic [CNT_W-1:0]      cnt, cnt_nx;
  logic [DATA_WIDTH-1:0] job_data_q, job_data_nx;
  logic                  abort_q, abort_nx;
  logic                  peer_enable_nx;
  logic [1:0]            peer_cmd_nx;
  logic [DATA_WIDTH-1:0] peer_data_in_nx;
  logic                  job_ready_q, job_ready_nx;
  logic                  res_valid_q, res_valid_nx;
  logic [DATA_WIDTH-1:0] res_data_q, res_data_nx;
  logic [1:0]            res_status_q, res_status_nx;
  logic                  host_busy_nx;
  logic                  timed_out;

  // peer_busy is informational only; it never gates the FSM.
  logic unused_peer_busy;
  assign unused_peer_busy = peer_busy;

`ifdef FSM_DUT_HOST_CHECK_EN
  localparam logic [1:0] ST_MISMATCH = 2'b11;
  logic [DATA_WIDTH-1:0] expect_q, expect_nx;

  function automatic logic [DATA_WIDTH-1:0] expected_result(input logic [DATA_WIDTH-1:0] d);
    logic [DATA_WIDTH-1:0] t;
    t = d + DATA_WIDTH'(1);
    t = t << 1;
    t = t ^ DATA_WIDTH'(8'hAA);
    return t + DATA_WIDTH'(8'h55);
  endfunction
`endif

  // The final waiting cycle is the one where the counter has reached TIMEOUT_CYCLES-1.
  assign timed_out = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  assign job_bus.job_ready  = job_ready_q;
  assign job_bus.res_valid  = res_valid_q;
  assign job_bus.res_data   = res_data_q;
  assign job_bus.res_status = res_status_q;

  // Next-state logic; outputs are derived from the next state so they register cleanly.
  always_comb begin
    state_nx      = state;
    cnt_nx        = '0;
    job_data_nx   = job_data_q;
    abort_nx      = abort_q;
    peer_data_in_nx = peer_data_in;
    res_data_nx   = res_data_q;
    res_status_nx = res_status_q;
`ifdef FSM_DUT_HOST_CHECK_EN
    expect_nx     = expect_q;
`endif
    case (state)
      H_IDLE: begin
        if (job_bus.job_valid && job_ready_q) begin
          job_data_nx     = job_bus.job_data;
          abort_nx        = job_bus.job_abort;
          peer_data_in_nx = job_bus.job_data;
`ifdef FSM_DUT_HOST_CHECK_EN
          expect_nx       = expected_result(job_bus.job_data);
`endif
          state_nx        = H_ISSUE;
        end
      end
      H_ISSUE: state_nx = H_WAIT_PEER;
      H_WAIT_PEER: begin
        if (peer_state == PEER_WAIT) state_nx = H_DECIDE;
        else if (timed_out)          state_nx = H_KILL;
        else                         cnt_nx   = cnt + CNT_W'(1);
      end
      H_DECIDE: state_nx = abort_q ? H_WAIT_IDLE : H_WAIT_DONE;
      H_WAIT_DONE: begin
        if (peer_done && peer_valid) begin
          res_data_nx   = peer_data_out;
          res_status_nx = ST_OK;
`ifdef FSM_DUT_HOST_CHECK_EN
          if (peer_data_out != expect_q) res_status_nx = ST_MISMATCH;
`endif
          state_nx      = H_REPORT;
        end else if (timed_out) begin
          state_nx = H_KILL;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      H_WAIT_IDLE: begin
        if (peer_state == PEER_IDLE) begin
          res_status_nx = ST_ABORTED;
          res_data_nx   = '0;
          state_nx      = H_REPORT;
        end else if (timed_out) begin
          res_status_nx = ST_TIMEOUT;
          res_data_nx   = '0;
          state_nx      = H_REPORT;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      H_KILL: begin
        res_status_nx = ST_TIMEOUT;
        res_data_nx   = '0;
        state_nx      = H_REPORT;
      end
      H_REPORT: begin
        if (res_valid_q && job_bus.res_ready) state_nx = H_IDLE;
      end
      default: state_nx = H_IDLE;
    endcase

    peer_enable_nx = (state_nx == H_ISSUE);
    case (state_nx)
      H_ISSUE:  peer_cmd_nx = CMD_START;
      H_DECIDE: peer_cmd_nx = abort_nx ? CMD_ABORT : CMD_COMMIT;
      H_KILL:   peer_cmd_nx = CMD_ABORT;
      default:  peer_cmd_nx = CMD_NOP;
    endcase
    res_valid_nx = (state_nx == H_REPORT);
    job_ready_nx = (state_nx == H_IDLE) && !res_valid_nx;
    host_busy_nx = (state_nx != H_IDLE);
  end

  // State and registered outputs; reset drops any job in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= H_IDLE;
      cnt          <= '0;
      job_data_q   <= '0;
      abort_q      <= 1'b0;
      peer_enable  <= 1'b0;
      peer_cmd     <= CMD_NOP;
      peer_data_in <= '0;
      job_ready_q  <= 1'b0;
      res_valid_q  <= 1'b0;
      res_data_q   <= '0;
      res_status_q <= ST_OK;
      host_busy    <= 1'b0;
`ifdef FSM_DUT_HOST_CHECK_EN
      expect_q     <= '0;
`endif
    end else begin
      state        <= state_nx;
      cnt          <= cnt_nx;
      job_data_q   <= job_data_nx;
      abort_q      <= abort_nx;
      peer_enable  <= peer_enable_nx;
      peer_cmd     <= peer_cmd_nx;
      peer_data_in <= peer_data_in_nx;
      job_ready_q  <= job_ready_nx;
      res_valid_q  <= res_valid_nx;
      res_data_q   <= res_data_nx;
      res_status_q <= res_status_nx;
      host_busy    <= host_busy_nx;
`ifdef FSM_DUT_HOST_CHECK_EN
      expect_q     <= expect_nx;
`endif
    end
  end

endmodule

// File: tb/tb_fsm_dut_host.sv
// Testbench for fsm_dut_host: behavioural engine stub, scoreboard queue of
// expected results, independent monitor.
`timescale 1ns/1ps
module tb_fsm_dut_host;
  localparam int DW = 8;
  localparam int TO = 16;
`ifdef FSM_DUT_HOST_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  typedef struct {
    int status;
    int data;
    int starts;
    int commits;
    int aborts;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          peer_enable;
  logic [1:0]    peer_cmd;
  logic [DW-1:0] peer_data_in;
  logic [1:0]    peer_state;
  logic          peer_busy, peer_done, peer_valid;
  logic [DW-1:0] peer_data_out;
  logic          host_busy;

  fsm_dut_host_if #(.DATA_WIDTH(DW)) bus ();

  fsm_dut_host #(.DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .job_bus(bus),
    .peer_enable(peer_enable), .peer_cmd(peer_cmd), .peer_data_in(peer_data_in),
    .peer_state(peer_state), .peer_busy(peer_busy), .peer_done(peer_done),
    .peer_valid(peer_valid), .peer_data_out(peer_data_out), .host_busy(host_busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;
  int cyc = 0, acc_cyc = 0, n_results = 0, jobs_pushed = 0;
  int n_start = 0, n_commit = 0, n_abort = 0;
  exp_t sb[$];
  int cfg_dead = 0, cfg_p = 0, cfg_d = 0, cfg_a = 0, cfg_corrupt = 0;
  bit bp_hold = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int model_f(input int d);
    return ((((d + 1) << 1) ^ 'hAA) + 'h55) & 'hFF;
  endfunction

  function automatic exp_t mk(input int s, input int d, input int st, input int c, input int a);
    exp_t e;
    e.status = s; e.data = d; e.starts = st; e.commits = c; e.aborts = a;
    return e;
  endfunction

  // Reference: outcome of one job from the engine's delays and the timeout rule.
  function automatic exp_t predict(input int d, input int ab, input int dead, input int p,
                                   input int dd, input int a, input int corrupt);
    if (dead != 0 || p + 2 > TO) return mk(2, 0, 1, 0, 1);
    if (ab != 0) return (a + 1 > TO) ? mk(2, 0, 1, 0, 1) : mk(1, 0, 1, 0, 1);
    if (dd + 1 > TO) return mk(2, 0, 1, 1, 1);
    return mk((corrupt != 0 && CHECK_EN) ? 3 : 0, model_f(d) ^ corrupt, 1, 1, 0);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Engine stub: idle -> process (P cycles) -> wait -> complete (D cycles) -> idle.
  logic [1:0] e_state;
  int e_pcnt, e_dcnt, e_acnt, e_d, e_a, e_ab;
  bit e_drain;
  logic [DW-1:0] e_res;
  assign peer_state    = e_state;
  assign peer_busy     = (e_state != 2'b00);
  assign peer_done     = (e_state == 2'b11) && (e_dcnt == 0);
  assign peer_valid    = peer_done;
  assign peer_data_out = e_res;

  always @(posedge clk) begin
    if (reset) begin
      e_state <= 2'b00; e_drain <= 1'b0; e_pcnt <= 0; e_dcnt <= 0; e_acnt <= 0; e_res <= '0;
    end else begin
      case (e_state)
        2'b00: if (peer_enable && peer_cmd == 2'b01 && cfg_dead == 0) begin
          e_state <= 2'b01; e_pcnt <= cfg_p; e_d <= cfg_d; e_a <= cfg_a; e_ab <= int'(bus.job_abort);
          e_res <= DW'(model_f(int'(peer_data_in)) ^ cfg_corrupt);
        end
        2'b01: if (peer_cmd == 2'b11) e_state <= 2'b00;
               else if (e_pcnt == 0) e_state <= 2'b10;
               else e_pcnt <= e_pcnt - 1;
        2'b10: if (e_drain) begin
                 if (e_acnt <= 1) begin e_state <= 2'b00; e_drain <= 1'b0; end
                 else e_acnt <= e_acnt - 1;
               end else if (peer_cmd == 2'b10) begin
                 e_state <= 2'b11; e_dcnt <= e_d;
               end else if (peer_cmd == 2'b11) begin
                 if (e_a == 0) e_state <= 2'b00;
                 else begin e_drain <= 1'b1; e_acnt <= e_a; end
               end
        default: if (peer_cmd == 2'b11 || e_dcnt == 0) e_state <= 2'b00;
                 else e_dcnt <= e_dcnt - 1;
      endcase
    end
  end

  // Downstream ready: random, or held low for backpressure sequences.
  initial begin
    bus.res_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      bus.res_ready = bp_hold ? 1'b0 : ($urandom_range(0, 99) < 65);
    end
  end

  // Monitor: command pulses, result stability, scoreboard pops.
  initial begin
    bit lv, lr;
    int ld, ls;
    exp_t e;
    lv = 1'b0; lr = 1'b0; ld = 0; ls = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        n_start = 0; n_commit = 0; n_abort = 0; lv = 1'b0;
        continue;
      end
      if (bus.job_valid && bus.job_ready) acc_cyc = cyc;
      if (peer_enable || peer_cmd == 2'b01)
        check("enable_with_start", int'(peer_enable), int'(peer_cmd == 2'b01));
      case (peer_cmd)
        2'b01: begin n_start++; check("start_latency", cyc - acc_cyc, 1); end
        2'b10: n_commit++;
        2'b11: n_abort++;
        default: ;
      endcase
      if (bus.res_valid) begin
        check("job_ready_in_report", int'(bus.job_ready), 0);
        check("busy_in_report", int'(host_busy), 1);
        if (lv && !lr) begin
          check("hold_data", int'(bus.res_data), ld);
          check("hold_status", int'(bus.res_status), ls);
        end
      end
      if (bus.res_valid && bus.res_ready) begin
        if (sb.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_result: status %0d data 0x%0h with no job outstanding",
                   bus.res_status, bus.res_data);
        end else begin
          e = sb.pop_front();
          check("res_status", int'(bus.res_status), e.status);
          check("res_data", int'(bus.res_data), e.data);
          check("start_pulses", n_start, e.starts);
          check("commit_pulses", n_commit, e.commits);
          check("abort_pulses", n_abort, e.aborts);
        end
        n_results++;
        n_start = 0; n_commit = 0; n_abort = 0;
      end
      lv = bus.res_valid; lr = bus.res_ready; ld = int'(bus.res_data); ls = int'(bus.res_status);
    end
  end

  task automatic issue_job(input int d, input int ab, input int dead, input int p,
                           input int dd, input int a, input int corrupt, input exp_t e);
    int t;
    bit got;
    @(posedge clk); #1;
    cfg_dead = dead; cfg_p = p; cfg_d = dd; cfg_a = a; cfg_corrupt = corrupt;
    bus.job_data = DW'(d); bus.job_abort = (ab != 0); bus.job_valid = 1'b1;
    got = 1'b0; t = 0;
    while (!got && t < 200) begin
      @(negedge clk);
      if (bus.job_ready) got = 1'b1; else t++;
    end
    check("job_accepted", int'(got), 1);
    @(posedge clk); #1;
    bus.job_valid = 1'b0; bus.job_data = DW'($urandom); bus.job_abort = 1'($urandom_range(0, 1));
    if (got) begin sb.push_back(e); jobs_pushed++; end
  endtask

  task automatic wait_result();
    int t;
    t = 0;
    while (n_results < jobs_pushed && t < 400) begin @(negedge clk); t++; end
    check("result_returned", n_results, jobs_pushed);
  endtask

  task automatic run_job(input int d, input int ab, input int dead, input int p,
                         input int dd, input int a, input int corrupt, input exp_t e);
    issue_job(d, ab, dead, p, dd, a, corrupt, e);
    wait_result();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_job_ready"}, int'(bus.job_ready), 0);
    check({tag, "_peer_enable"}, int'(peer_enable), 0);
    check({tag, "_peer_cmd"}, int'(peer_cmd), 0);
    check({tag, "_peer_data_in"}, int'(peer_data_in), 0);
    check({tag, "_res_valid"}, int'(bus.res_valid), 0);
    check({tag, "_res_data"}, int'(bus.res_data), 0);
    check({tag, "_res_status"}, int'(bus.res_status), 0);
    check({tag, "_host_busy"}, int'(host_busy), 0);
  endtask

  initial begin
    int plist[6];
    int dlist[5];
    int alist[4];
    int d, ab, dead, p, dd, a, cor, t, saved;
    plist = '{0, 1, 2, 3, 14, 15};
    dlist = '{0, 1, 2, 15, 16};
    alist = '{0, 1, 15, 16};
    bus.job_valid = 1'b0; bus.job_data = '0; bus.job_abort = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_values("rst");
    @(posedge clk); #1;
    reset = 1'b0; bp_hold = 1'b0;
    @(posedge clk); @(negedge clk);
    check("ready_after_reset", int'(bus.job_ready), 1);

    // Directed: commit, wrap cases, abort, corrupt result.
    run_job('h10, 0, 0, 1, 0, 0, 0, mk(0, 'hDD, 1, 1, 0));
    run_job('hFF, 0, 0, 0, 1, 0, 0, mk(0, 'hFF, 1, 1, 0));
    run_job('h80, 0, 0, 2, 2, 0, 0, mk(0, 'hFD, 1, 1, 0));
    run_job('h10, 1, 0, 2, 0, 0, 0, mk(1, 'h00, 1, 0, 1));
    run_job('h10, 0, 0, 1, 0, 0, 1, mk(CHECK_EN ? 3 : 0, 'hDC, 1, 1, 0));

    // Engine never leaves idle: kill on the last waiting cycle.
    issue_job('h10, 0, 1, 0, 0, 0, 0, mk(2, 0, 1, 0, 1));
    t = 0;
    while (peer_cmd != 2'b11 && t < 60) begin @(negedge clk); t++; end
    check("kill_cycle", cyc - acc_cyc, TO + 2);
    wait_result();

    // Boundaries: condition on the last waiting cycle wins; one later times out.
    run_job('h10, 0, 0, 14, 0, 0, 0, mk(0, 'hDD, 1, 1, 0));
    run_job('h10, 0, 0, 15, 0, 0, 0, mk(2, 0, 1, 0, 1));
    run_job('h21, 0, 0, 0, 15, 0, 0, mk(0, model_f('h21), 1, 1, 0));
    run_job('h21, 0, 0, 0, 16, 0, 0, mk(2, 0, 1, 1, 1));
    run_job('h33, 1, 0, 0, 0, 15, 0, mk(1, 0, 1, 0, 1));
    run_job('h33, 1, 0, 0, 0, 16, 0, mk(2, 0, 1, 0, 1));

    // Randomized jobs against the reference outcome.
    for (int i = 0; i < 40; i++) begin
      d    = int'($urandom_range(0, 255));
      ab   = ($urandom_range(0, 99) < 30) ? 1 : 0;
      dead = ($urandom_range(0, 99) < 5) ? 1 : 0;
      p    = plist[$urandom_range(0, 5)];
      dd   = dlist[$urandom_range(0, 4)];
      a    = (p >= 15) ? 0 : alist[$urandom_range(0, 3)];
      cor  = ($urandom_range(0, 99) < 15) ? 1 : 0;
      run_job(d, ab, dead, p, dd, a, cor, predict(d, ab, dead, p, dd, a, cor));
    end

    // Backpressure: result held stable while downstream stalls.
    bp_hold = 1'b1;
    issue_job('h10, 0, 0, 1, 0, 0, 0, mk(0, 'hDD, 1, 1, 0));
    t = 0;
    while (!bus.res_valid && t < 80) begin @(negedge clk); t++; end
    repeat (10) begin
      @(negedge clk);
      check("bp_res_valid", int'(bus.res_valid), 1);
      check("bp_job_ready", int'(bus.job_ready), 0);
      check("bp_res_data", int'(bus.res_data), 'hDD);
      check("bp_res_status", int'(bus.res_status), 0);
    end
    bp_hold = 1'b0;
    wait_result();

    // Reset in the middle of a job's wait for the engine: job dropped silently.
    issue_job('h44, 0, 1, 0, 0, 0, 0, mk(2, 0, 1, 0, 1));
    repeat (5) @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); @(negedge clk);
    check_reset_values("midrst");
    @(posedge clk); #1;
    reset = 1'b0;
    sb.delete();
    jobs_pushed = n_results;
    saved = n_results;
    repeat (30) @(negedge clk);
    check("no_result_after_reset", n_results, saved);
    check("ready_after_midrst", int'(bus.job_ready), 1);

    run_job('h10, 0, 0, 1, 0, 0, 0, mk(0, 'hDD, 1, 1, 0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit, tests %0d failed %0d", n_tests, n_fail);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/fsm_dut_host.md
Name: fsm_dut_host

Overview:
- Initiator-side driver for the 4-state processing engine's command interface (enable, 2-bit command, data in; state, busy, done, valid, data out).
- Takes jobs from an upstream valid/ready port and issues start, then commit or abort, to the engine.
- Captures the engine's result and returns it with a status code on a downstream valid/ready port.
- Sits between a test sequencer or CPU-side queue and one engine instance; handles one job at a time.

Parameters:
- DATA_WIDTH, 8, width of job data, engine data and result data.
- TIMEOUT_CYCLES, 16, maximum consecutive cycles in any wait state before the host gives up (minimum 2).

Ports:
- clk  in  1  clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- job_valid  in  1  upstream job offered.
- job_ready  out  1  host can accept a job.
- job_data  in  DATA_WIDTH  operand for the engine.
- job_abort  in  1  1 = abort the job at the engine's wait phase instead of committing.
- peer_enable  out  1  engine enable.
- peer_cmd  out  2  engine command: 00 nop, 01 start, 10 commit, 11 abort.
- peer_data_in  out  DATA_WIDTH  operand driven to the engine.
- peer_state  in  2  engine state: 00 idle, 01 process, 10 wait, 11 complete.
- peer_busy  in  1  engine busy (observed only; does not gate the host FSM).
- peer_done  in  1  engine done pulse.
- peer_valid  in  1  engine data_out valid.
- peer_data_out  in  DATA_WIDTH  engine result.
- res_valid  out  1  result available.
- res_ready  in  1  downstream accepts result.
- res_data  out  DATA_WIDTH  captured result; 0 for non-OK status.
- res_status  out  2  00 ok, 01 aborted, 10 timeout, 11 mismatch.
- host_busy  out  1  high whenever the FSM is not in H_IDLE.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high. All outputs are registered.
- Reset values:
  - State H_IDLE.
  - job_ready=0 during reset, then 1 from the first cycle after reset deasserts.
  - peer_enable=0, peer_cmd=00, peer_data_in=0.
  - res_valid=0, res_data=0, res_status=00, host_busy=0, timeout counter=0.
- Reset mid-job drops the job silently: no result is produced and peer_cmd returns to 00.
- job_ready = (state==H_IDLE) && !res_valid. A job is accepted on job_valid && job_ready; job_data and job_abort are latched.
- H_IDLE -> H_ISSUE on accept.
- H_ISSUE: lasts exactly 1 cycle. peer_enable=1, peer_cmd=01, peer_data_in=latched data. Then -> H_WAIT_PEER.
- H_WAIT_PEER: peer_enable=0, peer_cmd=00.
  - When peer_state==10 is sampled -> H_DECIDE.
  - Timeout -> H_KILL.
- H_DECIDE: lasts 1 cycle.
  - peer_cmd=10 if latched abort==0, else 11.
  - Next state -> H_WAIT_DONE if commit, H_WAIT_IDLE if abort.
- H_WAIT_DONE:
  - On peer_done && peer_valid: capture peer_data_out, status 00 -> H_REPORT.
  - Timeout -> H_KILL.
- H_WAIT_IDLE:
  - On peer_state==00: status 01, data 0 -> H_REPORT.
  - Timeout -> status 10 -> H_REPORT.
- H_KILL: lasts 1 cycle. peer_cmd=11 (abort), status 10, data 0 -> H_REPORT.
- H_REPORT: res_valid=1 and held stable until res_valid && res_ready, then res_valid=0 -> H_IDLE. res_data and res_status stay stable while res_valid=1.
- Timeout counter:
  - Cleared on entry to every wait state.
  - Increments each cycle the expected condition is absent.
  - Timeout fires when it reaches TIMEOUT_CYCLES-1, i.e. on the TIMEOUT_CYCLES-th waiting cycle.
  - Width is the ceiling of log2(TIMEOUT_CYCLES).
- Simultaneous events: an expected condition sampled in the same cycle as the timeout wins; no timeout is reported.
- peer_cmd is 00 in every state except H_ISSUE, H_DECIDE and H_KILL. Every command is a 1-cycle pulse.
- Latency: job accepted in cycle N -> start command visible in cycle N+1.
- Back-to-back jobs: earliest next accept is the cycle after the result handshake completes.

Optional Feature:
- Macro FSM_DUT_HOST_CHECK_EN.
- Defined:
  - On job accept, compute the expected result at DATA_WIDTH, modulo 2^DATA_WIDTH: ((((d+1)<<1) ^ 0xAA) + 0x55). The constants are zero-extended/truncated to DATA_WIDTH.
  - In H_WAIT_DONE, if the captured value differs from the expected result: status 11, and res_data holds the captured (wrong) value.
- Not defined: no model logic is built and status 11 is never produced.

Test Plan:
- Commit: job_data=0x10, job_abort=0, engine connected -> one result, res_data=0xDD, res_status=00; peer_cmd shows exactly one 01 pulse and one 10 pulse.
- Wrap: job_data=0xFF -> res_data=0xFF, status 00; job_data=0x80 -> res_data=0xFD, status 00.
- Abort: job_data=0x10, job_abort=1 -> peer_cmd=11 issued when peer_state==10, res_status=01, res_data=0x00, engine returns to idle.
- Timeout: peer_state tied to 00 -> H_KILL reached on the 16th cycle of H_WAIT_PEER, peer_cmd=11 for 1 cycle, res_status=10, job_ready=0 until res_ready.
- Backpressure and reset: hold res_ready=0 for 10 cycles -> res_valid, res_data and res_status stable and job_ready=0; then assert reset in the middle of a second job's H_WAIT_PEER -> all outputs at reset values the next cycle, no result emitted.
- Check feature (FSM_DUT_HOST_CHECK_EN): stub engine returns 0xDC for job 0x10 -> res_status=11, res_data=0xDC.
